// File: rtl/disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : disp_pkg                                                   |
// | Shared seven-segment constants for the multiplexed hex display.      |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package disp_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // {g,f,e,d,c,b,a}, active-low; 6 and 9 carry their tails (MC14495 style)
    localparam logic [6:0] c_hex_seg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage
`default_nettype wire

// File: rtl/hex7seg_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : hex7seg_dec                                                 |
// | Combinational 4-bit hex to active-low a-g segment decoder.           |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module hex7seg_dec
    import disp_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = c_hex_seg[i_hex];

endmodule
`default_nettype wire

// File: rtl/disp_scan_hex.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : disp_scan_hex                                               |
// | Time-multiplexed hex display driver with blanking, LZ and blink.     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module disp_scan_hex
    import disp_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_SLOTS = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hexs,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     les,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lz_en,
    output logic [7:0]            segment,
    output logic [DIGITS-1:0]     anode
);

    localparam int c_idx_w  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_pre_w  = $clog2(SCAN_DIV);
    localparam int c_slot_w = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    logic [4*DIGITS-1:0] r_hexs;
    logic [DIGITS-1:0]   r_points;
    logic [DIGITS-1:0]   r_les;
    logic [DIGITS-1:0]   r_blink;
    logic [c_pre_w-1:0]  r_pre;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_slot_w-1:0] r_slot;
    logic                r_phase;
    logic [7:0]          r_segment;
    logic [DIGITS-1:0]   r_anode;

    logic                w_tick;
    logic [DIGITS-1:0]   w_hi_zero;
    logic                w_zero_run;
    logic [3:0]          w_cur_hex;
    logic                w_cur_pt;
    logic                w_cur_le;
    logic                w_cur_bl;
    logic                w_cur_hz;
    logic [6:0]          w_dec_seg;
    logic                w_ag_blank;
    logic [7:0]          w_seg_next;
    logic [DIGITS-1:0]   w_anode_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hexs   <= '0;
            r_points <= '0;
            r_les    <= '0;
            r_blink  <= '0;
        end else if (load) begin
            r_hexs   <= hexs;
            r_points <= points;
            r_les    <= les;
            r_blink  <= blink;
        end
    end

    assign w_tick = (r_pre == c_pre_w'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_slot  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == c_idx_w'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
                if (r_slot == c_slot_w'(BLINK_SLOTS - 1)) begin
                    r_slot  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_slot <= r_slot + 1'b1;
                end
            end
        end
    end

    // w_hi_zero[i]: digit i and every digit above it hold zero
    always_comb begin
        w_hi_zero  = '0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run   = w_zero_run & (r_hexs[4*i +: 4] == 4'h0);
            w_hi_zero[i] = w_zero_run;
        end
    end

    always_comb begin
        w_cur_hex = 4'h0;
        w_cur_pt  = 1'b0;
        w_cur_le  = 1'b0;
        w_cur_bl  = 1'b0;
        w_cur_hz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_cur_hex = r_hexs[4*i +: 4];
                w_cur_pt  = r_points[i];
                w_cur_le  = r_les[i];
                w_cur_bl  = r_blink[i];
                w_cur_hz  = w_hi_zero[i];
            end
        end
    end

    hex7seg_dec u_dec (
        .i_hex (w_cur_hex),
        .o_seg (w_dec_seg)
    );

    // Digit 0 is exempt from suppression so an all-zero value still shows "0"
    assign w_ag_blank   = w_cur_le | (lz_en & (r_idx != '0) & w_cur_hz);
    assign w_seg_next   = (w_cur_bl & r_phase) ? SEG_OFF
                        : {~w_cur_pt, (w_ag_blank ? 7'h7F : w_dec_seg)};
    assign w_anode_next = ~(DIGITS'(1) << r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segment <= SEG_OFF;
            r_anode   <= '1;
        end else begin
            r_segment <= w_seg_next;
            r_anode   <= w_anode_next;
        end
    end

    assign segment = r_segment;
    assign anode   = r_anode;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_hex.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_disp_scan_hex                                            |
// | Randomized bench with a slot-arithmetic display model, two configs.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_disp_scan_hex;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        load   = 1'b0;
    logic        lz_en  = 1'b0;
    logic [15:0] hexs   = '0;
    logic [3:0]  points = '0;
    logic [3:0]  les    = '0;
    logic [3:0]  blink  = '0;

    logic [7:0]  seg_a;
    logic [3:0]  an_a;
    logic [7:0]  seg_b;
    logic [2:0]  an_b;

    int n_checks = 0;
    int n_fail   = 0;

    // model: edges since reset release plus the captured display data
    int          m = 0;
    logic [15:0] sh_h = '0;
    logic [3:0]  sh_p = '0;
    logic [3:0]  sh_l = '0;
    logic [3:0]  sh_b = '0;

    always #5 clk = ~clk;

    disp_scan_hex #(.DIGITS(4), .SCAN_DIV(4), .BLINK_SLOTS(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .hexs(hexs), .points(points),
        .les(les), .blink(blink), .lz_en(lz_en), .segment(seg_a), .anode(an_a)
    );

    disp_scan_hex #(.DIGITS(3), .SCAN_DIV(2), .BLINK_SLOTS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .hexs(hexs[11:0]), .points(points[2:0]),
        .les(les[2:0]), .blink(blink[2:0]), .lz_en(lz_en), .segment(seg_b), .anode(an_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_pat(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Output after an edge reflects the state after n edges: slot t = n/div
    function automatic logic [7:0] exp_seg(input int nd, input int sdiv, input int bsl,
                                           input int n, input logic [15:0] h,
                                           input logic [3:0] p, input logic [3:0] l,
                                           input logic [3:0] b, input logic lz);
        int   t   = n / sdiv;
        int   i   = t % nd;
        bit   ph  = ((t / bsl) % 2) == 1;
        bit   hz  = 1'b1;
        logic [7:0] r;
        for (int k = i; k < nd; k++)
            if (h[4*k +: 4] != 4'h0) hz = 1'b0;
        if (b[i] && ph) return 8'hFF;
        r = hex_pat(h[4*i +: 4]);
        if (l[i] || (lz && i > 0 && hz)) r = 8'hFF;
        r[7] = ~p[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_an(input int nd, input int sdiv, input int n);
        int i = (n / sdiv) % nd;
        return ~(32'd1 << i) & ((32'd1 << nd) - 1);
    endfunction

    task automatic step();
        logic [7:0]  es_a, es_b;
        logic [31:0] ea, eb;
        @(posedge clk);
        es_a = exp_seg(4, 4, 3, m, sh_h, sh_p, sh_l, sh_b, lz_en);
        ea   = exp_an(4, 4, m);
        es_b = exp_seg(3, 2, 2, m, sh_h, sh_p, sh_l, sh_b, lz_en);
        eb   = exp_an(3, 2, m);
        if (load) begin
            sh_h = hexs; sh_p = points; sh_l = les; sh_b = blink;
        end
        m++;
        #1;
        check("seg_a", {24'h0, seg_a}, {24'h0, es_a});
        check("anode_a", {28'h0, an_a}, ea);
        check("seg_b", {24'h0, seg_b}, {24'h0, es_b});
        check("anode_b", {29'h0, an_b}, eb);
    endtask

    task automatic load_once(input logic [15:0] h, input logic [3:0] p,
                             input logic [3:0] l, input logic [3:0] b);
        hexs = h; points = p; les = l; blink = b; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_reset_check(input string tag);
        check({tag, "_seg_a"}, {24'h0, seg_a}, 32'hFF);
        check({tag, "_an_a"},  {28'h0, an_a},  32'hF);
        check({tag, "_seg_b"}, {24'h0, seg_b}, 32'hFF);
        check({tag, "_an_b"},  {29'h0, an_b},  32'h7);
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m = 0; sh_h = '0; sh_p = '0; sh_l = '0; sh_b = '0;
        step();
        check("first_edge_an", {28'h0, an_a}, 32'hE);
        check("first_edge_seg", {24'h0, seg_a}, 32'hC0);
    endtask

    function automatic logic [15:0] rand_hex();
        logic [15:0] h = 16'($urandom);
        for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 2) == 0) h[4*k +: 4] = 4'h0;
        return h;
    endfunction

    initial begin
        #2 rst_n = 1'b0;
        #1 do_reset_check("rst_async");
        release_reset();

        // F,A,2,1 scan order from digit 0 upward
        load_once(16'h12AF, 4'h0, 4'h0, 4'h0);
        repeat (32) step();

        lz_en = 1'b1;
        load_once(16'h0070, 4'h0, 4'h0, 4'h0);
        repeat (16) step();
        load_once(16'h0000, 4'h0, 4'h0, 4'h0);
        repeat (16) step();

        lz_en = 1'b0;
        load_once(16'h0080, 4'b0010, 4'b0010, 4'h0);
        repeat (16) step();

        load_once(rand_hex(), 4'($urandom), 4'h0, 4'b0001);
        repeat (48) step();

        // load landing on a tick edge
        for (int k = 0; k < 4 && (m % 4) != 3; k++) step();
        check("tick_align", 32'(m % 4), 32'd3);
        load_once(rand_hex(), 4'($urandom), 4'h0, 4'h0);
        repeat (16) step();

        for (int c = 0; c < 400; c++) begin
            hexs   = rand_hex();
            points = 4'($urandom);
            les    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            blink  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            load   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
            step();
        end
        load = 1'b0;

        // reset asserted between edges, part way through a slot
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1 do_reset_check("rst_mid");
        release_reset();
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
